// File: rtl/calc_key_arbiter.sv
// calc_key_arbiter
//
// Merges key events from the PS/2 keyboard decoder (source 0) and the
// on-board button-grid navigator (source 1) into the single
// key_ascii/key_pressed channel that drives the calculator display.
// Each source has its own FIFO. A two-state scheduler (IDLE/GAP) grants
// the sources round-robin, except that an ESC at exactly one FIFO head
// wins. After every output pulse the scheduler idles for GAP_CYCLES+1
// cycles, so the display's per-key button highlight stays visible.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   kb_ascii     keyboard ASCII code, qualified by kb_valid
//   kb_valid     one-cycle write strobe for the keyboard FIFO
//   btn_ascii    button-navigator ASCII code, qualified by btn_valid
//   btn_valid    one-cycle write strobe for the button FIFO
//   flush        discard all queued keys and abort any pacing gap
//   key_ascii    merged key code (holds its value between pulses)
//   key_pressed  one-cycle pulse, key_ascii is valid in that cycle
//   busy         a FIFO is non-empty or the scheduler is not IDLE
//   drop_cnt     saturating count of keys rejected by a full FIFO

module calc_key_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] kb_ascii,
    input  logic       kb_valid,
    input  logic [7:0] btn_ascii,
    input  logic       btn_valid,
    input  logic       flush,
    output logic [7:0] key_ascii,
    output logic       key_pressed,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [PTR_W:0]   PTR_ZERO = {(PTR_W + 1){1'b0}};
    localparam logic [PTR_W:0]   PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0] GAP_ONE  = {{(GAP_W - 1){1'b0}}, 1'b1};
    localparam logic [7:0]       ESC_CODE = 8'd27;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_e;

    // Pointers carry one extra wrap bit so that full and empty differ.
    function automatic logic fifo_full(input logic [PTR_W:0] wr, input logic [PTR_W:0] rd);
        return (wr[PTR_W] != rd[PTR_W]) && (wr[PTR_W-1:0] == rd[PTR_W-1:0]);
    endfunction

    function automatic logic fifo_empty(input logic [PTR_W:0] wr, input logic [PTR_W:0] rd);
        return wr == rd;
    endfunction

    // Adds 0..2 to an 8-bit counter, sticking at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0000000, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Registered state and its next-state values
    state_e           state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             key_pressed_q, key_pressed_d;
    logic [7:0]       key_ascii_q, key_ascii_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [PTR_W:0]   kb_wr_q, kb_wr_d, kb_rd_q, kb_rd_d;
    logic [PTR_W:0]   btn_wr_q, btn_wr_d, btn_rd_q, btn_rd_d;
    logic [7:0]       kb_mem_q  [FIFO_DEPTH];
    logic [7:0]       btn_mem_q [FIFO_DEPTH];

    // Combinational helpers
    logic [7:0] kb_head_s, btn_head_s;
    logic       kb_ne_s, btn_ne_s, kb_full_s, btn_full_s;
    logic       grant_s, sel_s;
    logic       kb_pop_s, btn_pop_s;
    logic       kb_wr_en_s, btn_wr_en_s;
    logic       kb_drop_s, btn_drop_s;
    logic [1:0] drop_inc_s;

    assign kb_head_s  = kb_mem_q[kb_rd_q[PTR_W-1:0]];
    assign btn_head_s = btn_mem_q[btn_rd_q[PTR_W-1:0]];
    assign kb_ne_s    = !fifo_empty(kb_wr_q, kb_rd_q);
    assign btn_ne_s   = !fifo_empty(btn_wr_q, btn_rd_q);
    assign kb_full_s  = fifo_full(kb_wr_q, kb_rd_q);
    assign btn_full_s = fifo_full(btn_wr_q, btn_rd_q);

    // Source selection, FIFO pop/push enables and drop detection
    always_comb begin
        sel_s = 1'b0;
        if (kb_ne_s && btn_ne_s) begin
            // A lone ESC at a head jumps ahead; otherwise alternate sources.
            if ((kb_head_s == ESC_CODE) != (btn_head_s == ESC_CODE)) begin
                sel_s = (btn_head_s == ESC_CODE);
            end else begin
                sel_s = ~last_grant_q;
            end
        end else if (btn_ne_s) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end

        // Flush dominates both the grant and any simultaneous write.
        grant_s   = (state_q == ST_IDLE) && (kb_ne_s || btn_ne_s) && !flush;
        kb_pop_s  = grant_s && !sel_s;
        btn_pop_s = grant_s && sel_s;

        // A full FIFO still accepts a write when it is popped in the same cycle.
        kb_wr_en_s  = kb_valid && !flush && (!kb_full_s || kb_pop_s);
        btn_wr_en_s = btn_valid && !flush && (!btn_full_s || btn_pop_s);
        kb_drop_s   = kb_valid && !flush && kb_full_s && !kb_pop_s;
        btn_drop_s  = btn_valid && !flush && btn_full_s && !btn_pop_s;
        drop_inc_s  = {1'b0, kb_drop_s} + {1'b0, btn_drop_s};
    end

    // Scheduler next-state, pointer and output-register updates
    always_comb begin
        state_d       = state_q;
        gap_cnt_d     = gap_cnt_q;
        last_grant_d  = last_grant_q;
        key_pressed_d = 1'b0;
        key_ascii_d   = key_ascii_q;
        drop_cnt_d    = drop_cnt_q;
        kb_wr_d       = kb_wr_q;
        kb_rd_d       = kb_rd_q;
        btn_wr_d      = btn_wr_q;
        btn_rd_d      = btn_rd_q;

        if (flush) begin
            state_d   = ST_IDLE;
            gap_cnt_d = GAP_ZERO;
            kb_wr_d   = PTR_ZERO;
            kb_rd_d   = PTR_ZERO;
            btn_wr_d  = PTR_ZERO;
            btn_rd_d  = PTR_ZERO;
        end else begin
            drop_cnt_d = sat_add8(drop_cnt_q, drop_inc_s);

            if (kb_wr_en_s) begin
                kb_wr_d = kb_wr_q + PTR_ONE;
            end else begin
                kb_wr_d = kb_wr_q;
            end
            if (btn_wr_en_s) begin
                btn_wr_d = btn_wr_q + PTR_ONE;
            end else begin
                btn_wr_d = btn_wr_q;
            end
            if (kb_pop_s) begin
                kb_rd_d = kb_rd_q + PTR_ONE;
            end else begin
                kb_rd_d = kb_rd_q;
            end
            if (btn_pop_s) begin
                btn_rd_d = btn_rd_q + PTR_ONE;
            end else begin
                btn_rd_d = btn_rd_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (grant_s) begin
                        key_pressed_d = 1'b1;
                        key_ascii_d   = sel_s ? btn_head_s : kb_head_s;
                        last_grant_d  = sel_s;
                        gap_cnt_d     = GAP_LOAD;
                        state_d       = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    // Counts GAP_CYCLES..0, giving GAP_CYCLES+1 cycles in GAP.
                    if (gap_cnt_q == GAP_ZERO) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_ONE;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = GAP_ZERO;
                end
            endcase
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            gap_cnt_q     <= GAP_ZERO;
            last_grant_q  <= 1'b1;
            key_pressed_q <= 1'b0;
            key_ascii_q   <= 8'h00;
            drop_cnt_q    <= 8'h00;
            kb_wr_q       <= PTR_ZERO;
            kb_rd_q       <= PTR_ZERO;
            btn_wr_q      <= PTR_ZERO;
            btn_rd_q      <= PTR_ZERO;
        end else begin
            state_q       <= state_d;
            gap_cnt_q     <= gap_cnt_d;
            last_grant_q  <= last_grant_d;
            key_pressed_q <= key_pressed_d;
            key_ascii_q   <= key_ascii_d;
            drop_cnt_q    <= drop_cnt_d;
            kb_wr_q       <= kb_wr_d;
            kb_rd_q       <= kb_rd_d;
            btn_wr_q      <= btn_wr_d;
            btn_rd_q      <= btn_rd_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (!reset && kb_wr_en_s) begin
            kb_mem_q[kb_wr_q[PTR_W-1:0]] <= kb_ascii;
        end
        if (!reset && btn_wr_en_s) begin
            btn_mem_q[btn_wr_q[PTR_W-1:0]] <= btn_ascii;
        end
    end

    assign key_pressed = key_pressed_q;
    assign key_ascii   = key_ascii_q;
    assign drop_cnt    = drop_cnt_q;
    assign busy        = kb_ne_s || btn_ne_s || (state_q != ST_IDLE);

endmodule

// File: tb/tb_calc_key_arbiter.sv
// Testbench for calc_key_arbiter. Stimulus pushes the expected key code and
// the expected pulse cycle into a queue; a monitor on the falling clock edge
// pops and compares whenever key_pressed is high.

module tb_calc_key_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] kb_ascii = 8'h00;
    logic       kb_valid = 1'b0;
    logic [7:0] btn_ascii = 8'h00;
    logic       btn_valid = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] key_ascii;
    logic       key_pressed;
    logic       busy;
    logic [7:0] drop_cnt;

    calc_key_arbiter #(.FIFO_DEPTH(4), .GAP_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .kb_ascii    (kb_ascii),
        .kb_valid    (kb_valid),
        .btn_ascii   (btn_ascii),
        .btn_valid   (btn_valid),
        .flush       (flush),
        .key_ascii   (key_ascii),
        .key_pressed (key_pressed),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [7:0] ascii;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every pulse must be one cycle wide and match the queue head.
    logic prev_kp = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (key_pressed === 1'b1) begin
            chk("pulse_width", {31'd0, prev_kp}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_pulse: key_ascii 0x%0h at cycle %0d, expected no key", key_ascii, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("key_ascii", {24'd0, key_ascii}, {24'd0, mon_e.ascii});
                if (mon_e.at >= 0) chk("pulse_cycle", cyc, mon_e.at);
            end
        end
        prev_kp = key_pressed;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic kv, input logic [7:0] ka, input logic bv, input logic [7:0] ba);
        kb_valid  = kv;
        kb_ascii  = ka;
        btn_valid = bv;
        btn_ascii = ba;
        tick();
        kb_valid  = 1'b0;
        btn_valid = 1'b0;
    endtask

    task automatic expect_key(input logic [7:0] a, input int at);
        exp_t e;
        e.ascii = a;
        e.at    = at;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk(name, {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
    endtask

    initial begin
        int c;
        int d;
        tick();
        do_reset();

        // Reset values
        chk("rst_key_pressed", {31'd0, key_pressed}, 32'd0);
        chk("rst_key_ascii", {24'd0, key_ascii}, 32'h00);
        chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Single key: pulse two cycles after the strobe, busy through GAP
        c = cyc;
        expect_key(8'h37, c + 2);
        drive(1'b1, 8'h37, 1'b0, 8'h00);
        chk("single_busy_queued", {31'd0, busy}, 32'd1);
        wait_until(c + 18);
        chk("single_busy_last_gap", {31'd0, busy}, 32'd1);
        tick();
        chk("single_busy_idle", {31'd0, busy}, 32'd0);
        chk("single_ascii_hold", {24'd0, key_ascii}, 32'h37);

        // Round-robin: kb {'1','2'}, btn {'8','9'} -> '1','8','2','9', 18 apart
        do_reset();
        c = cyc;
        expect_key(8'h31, c + 2);
        expect_key(8'h38, c + 20);
        expect_key(8'h32, c + 38);
        expect_key(8'h39, c + 56);
        drive(1'b1, 8'h31, 1'b1, 8'h38);
        drive(1'b1, 8'h32, 1'b1, 8'h39);
        drain("rr_drain", 100);

        // ESC at the button head beats the keyboard's round-robin turn
        do_reset();
        c = cyc;
        expect_key(8'd27, c + 2);
        expect_key(8'h35, c + 20);
        drive(1'b1, 8'h35, 1'b1, 8'd27);
        drain("esc_drain", 60);

        // Both heads ESC: round-robin picks the keyboard first
        do_reset();
        c = cyc;
        expect_key(8'd27, c + 2);
        expect_key(8'd27, c + 20);
        expect_key(8'h61, c + 38);
        expect_key(8'h62, c + 56);
        drive(1'b1, 8'd27, 1'b1, 8'd27);
        drive(1'b1, 8'h61, 1'b1, 8'h62);
        drain("esc_tie_drain", 100);

        // Overflow: six strobes during GAP, four kept in order, two dropped
        do_reset();
        c = cyc;
        expect_key(8'h78, c + 2);
        expect_key(8'h41, c + 20);
        expect_key(8'h42, c + 38);
        expect_key(8'h43, c + 56);
        expect_key(8'h44, c + 74);
        drive(1'b1, 8'h78, 1'b0, 8'h00);
        tick();
        for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h41 + i), 1'b0, 8'h00);
        chk("overflow_drop_cnt", {24'd0, drop_cnt}, 32'd2);
        drain("overflow_drain", 200);

        // Saturation: continuous keyboard strobes for 600 cycles, then flush
        do_reset();
        c = cyc;
        for (int k = 0; 2 + 18 * k <= 600; k++) expect_key(8'h4B, c + 2 + 18 * k);
        kb_ascii = 8'h4B;
        kb_valid = 1'b1;
        wait_until(c + 10);
        chk("sat_drop_early", {24'd0, drop_cnt}, 32'd5);
        wait_until(c + 600);
        kb_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sat_drop_cnt", {24'd0, drop_cnt}, 32'd255);
        chk("sat_busy_after_flush", {31'd0, busy}, 32'd0);
        repeat (40) tick();

        // Flush during GAP with simultaneous writes: queue discarded, no drop counted
        do_reset();
        c = cyc;
        expect_key(8'h78, c + 2);
        drive(1'b1, 8'h78, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h31 + i), 1'b0, 8'h00);
        chk("flush_pre_drop", {24'd0, drop_cnt}, 32'd1);
        flush = 1'b1;
        drive(1'b1, 8'h36, 1'b1, 8'h7A);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_key_pressed", {31'd0, key_pressed}, 32'd0);
        chk("flush_drop_kept", {24'd0, drop_cnt}, 32'd1);
        repeat (40) tick();
        chk("flush_stays_idle", {31'd0, busy}, 32'd0);
        // last_grant survived the flush (keyboard), so the button goes first
        d = cyc;
        expect_key(8'h70, d + 2);
        expect_key(8'h6B, d + 20);
        drive(1'b1, 8'h6B, 1'b1, 8'h70);
        drain("flush_rr_drain", 60);

        // Reset mid-GAP with keys queued and a drop recorded
        do_reset();
        c = cyc;
        expect_key(8'h78, c + 2);
        drive(1'b1, 8'h78, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h31 + i), 1'b0, 8'h00);
        chk("midgap_pre_drop", {24'd0, drop_cnt}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midgap_key_pressed", {31'd0, key_pressed}, 32'd0);
        chk("midgap_key_ascii", {24'd0, key_ascii}, 32'h00);
        chk("midgap_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        chk("midgap_busy", {31'd0, busy}, 32'd0);
        d = cyc;
        expect_key(8'h71, d + 2);
        drive(1'b1, 8'h71, 1'b0, 8'h00);
        drain("midgap_new_key", 60);

        repeat (30) tick();
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
